// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/shift ops and a WIDTH-step shift-add multiplier,
// with a valid/ready handshake on both the request and the result side.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7
    } op_t;

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [3:0]           flags_q, flags_d;

    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_y;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 accept;

    // Single-cycle datapath; SUB reuses the adder with an inverted B operand.
    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_SHL: begin
                alu_y = {a[WIDTH-2:0], cin};
                alu_c = a[WIDTH-1];
                alu_v = alu_y[WIDTH-1] ^ a[WIDTH-1];
            end
            OP_SHR: begin
                alu_y = {cin, a[WIDTH-1:1]};
                alu_c = a[0];
                alu_v = alu_y[WIDTH-1] ^ a[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign acc_step  = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign flags     = flags_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        y_d     = y_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: ;
            MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    y_d     = acc_step[WIDTH-1:0];
                    flags_d = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                               |acc_step[2*WIDTH-1:WIDTH], 1'b0};
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An accept in DONE consumes the held result and starts the new op on the same edge.
        if (accept) begin
            if (op == OP_MUL) begin
                state_d = MUL;
                cnt_d   = '0;
                acc_d   = '0;
                mcand_d = {{WIDTH{1'b0}}, a};
                mplr_d  = b;
            end else begin
                state_d = DONE;
                y_d     = alu_y;
                flags_d = {alu_y[WIDTH-1], alu_y == '0, alu_c, alu_v};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  3  opcode, per REQ-012.
REQ-007 a  input  WIDTH  operand A, unsigned bit vector.
REQ-008 b  input  WIDTH  operand B, unsigned bit vector.
REQ-009 cin  input  1  carry-in / shift-in bit.
REQ-010 out_valid  output  1  result y and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle; y  output  WIDTH  result; flags  output  4  {n,z,c,v}.

Function
REQ-012 Opcodes:
- 000 ADD: y=a+b+cin, c=carry-out, v=signed overflow.
- 001 SUB: y=a+~b+cin, c=carry-out (1 = no borrow), v=signed overflow.
- 010 AND, 011 OR, 100 XOR: bitwise, c=0, v=0.
- 101 SHL: y={a[W-2:0],cin}, c=a[W-1].
- 110 SHR: y={cin,a[W-1:1]}, c=a[0].
- For SHL/SHR: v=y[W-1]^a[W-1].
- 111 MUL: unsigned; y=low WIDTH bits of a*b; c=1 iff high WIDTH bits nonzero; v=0.
REQ-013 All ops: n=y[W-1]; z=1 iff y==0.
REQ-014 Accept occurs on a rising edge where in_valid&&in_ready; op, a, b, cin are captured at that edge; inputs are ignored at all other times.
REQ-015 FSM states IDLE, MUL, DONE.
- in_ready=1 in IDLE, and in DONE when out_ready=1.
- in_ready=0 in MUL, and in DONE when out_ready=0.
- in_ready is combinational from state and out_ready.
REQ-016 Non-MUL accept: result and flags are registered at the accept edge; state goes to DONE; latency is 1 edge.
REQ-017 MUL accept: state goes to MUL and a log2-sized iteration counter is cleared.
- One shift-add step per edge.
- The WIDTH-th step edge registers y and flags and enters DONE.
- out_valid rises exactly WIDTH edges after the accept edge.
REQ-018 out_valid=1 only in DONE.
REQ-019 In DONE with out_ready=0, y, flags and out_valid are held stable.
REQ-020 In DONE with out_ready=1 and no accept, state goes to IDLE and out_valid=0 next cycle.
REQ-021 In DONE with out_ready=1 and a simultaneous accept, the current result is consumed and the new request is processed per REQ-016/017 on that same edge. This gives sustained 1 result/cycle for non-MUL ops.
REQ-022 y and flags are registered outputs.
- Their values outside DONE are don't-care for consumers.
- They retain their last value except during MUL iterations and at reset.
REQ-023 Internal arithmetic uses a WIDTH+1-bit adder for ADD/SUB. The MUL accumulator is 2*WIDTH bits; no truncation occurs before final flag evaluation.

Reset
REQ-024 While rst=1:
- state=IDLE, out_valid=0, y=0, flags=0, iteration counter=0.
- These take effect immediately, without waiting for a clock edge.
REQ-025 rst asserted mid-MUL or in DONE discards the operation; no result is ever presented for it.
REQ-026 No accept occurs on any edge while rst=1. The first accept is possible on the first rising edge after rst deasserts, with in_ready=1.

Verification (WIDTH=8)
REQ-027 ADD a=0xFF b=0x01 cin=0 -> next cycle out_valid=1, y=0x00, n=0 z=1 c=1 v=0.
REQ-028 SUB a=0x80 b=0x01 cin=1 -> y=0x7F, n=0 z=0 c=1 v=1.
REQ-029 MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles, then out_valid=1 at edge 8, y=0x10, c=1 v=0 z=0.
REQ-030 SHL a=0x40 cin=1, with out_ready=0 for 5 cycles:
- Result y=0x81, n=1 c=0 v=1.
- y and flags are stable and in_ready=0 throughout, and a pending XOR is not accepted.
- Raising out_ready consumes the result and accepts the XOR on the same edge.
REQ-031 rst pulse 3 edges into a MUL -> out_valid, y and flags read 0 immediately. No out_valid follows; a subsequent ADD completes normally.
REQ-032 10 back-to-back XOR requests with out_ready=1 held -> 10 consecutive out_valid cycles with correct y, none dropped or duplicated.
